// File: rtl/mdu_ctrl_pkg.sv
// Shared opcode and state encodings for the multiply/divide unit and its datapath.
// Also holds the small op-class predicates used by both the controller and md_calc.
package mdu_ctrl_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    function automatic logic is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || is_div(op);
    endfunction

endpackage

// File: rtl/mdu_ctrl_calc.sv
// Combinational multiply/divide datapath: one shared 64-bit multiplier and a
// magnitude divider whose quotient/remainder signs are fixed up for DIV.
module md_calc
    import mdu_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div0
);

    logic        sgn_mul;
    logic        sgn_div;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] prod;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] dvs_safe;
    logic [31:0] uq;
    logic [31:0] ur;

    // MULT and MULTU differ only in how the operands are extended to 64 bits.
    assign sgn_mul = (op == MD_MULT);
    assign mul_a   = {{32{sgn_mul & a[31]}}, a};
    assign mul_b   = {{32{sgn_mul & b[31]}}, b};
    assign prod    = mul_a * mul_b;

    // DIV divides magnitudes; 0x80000000 maps to itself, which is its correct magnitude.
    assign sgn_div  = (op == MD_DIV);
    assign dvd      = (sgn_div && a[31]) ? (32'd0 - a) : a;
    assign dvs      = (sgn_div && b[31]) ? (32'd0 - b) : b;
    assign dvs_safe = (dvs == 32'd0) ? 32'd1 : dvs;
    assign uq       = dvd / dvs_safe;
    assign ur       = dvd % dvs_safe;

    always_comb begin
        hi   = 32'd0;
        lo   = 32'd0;
        div0 = is_div(op) && (b == 32'd0);
        case (op)
            MD_MULT, MD_MULTU: begin
                hi = prod[63:32];
                lo = prod[31:0];
            end
            MD_DIV: begin
                lo = (a[31] ^ b[31]) ? (32'd0 - uq) : uq;
                hi = a[31] ? (32'd0 - ur) : ur;
            end
            MD_DIVU: begin
                lo = uq;
                hi = ur;
            end
            default: begin
                hi = 32'd0;
                lo = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide sequencer: latches the result on start, holds busy for
// a fixed latency, then commits HI/LO; stalls D-stage HI/LO users meanwhile.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        rd_hi,
    input  logic        md_req,
    output logic        busy,
    output logic        stall,
    output logic [31:0] md_rdata
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             pend_skip_q, pend_skip_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic [31:0]      calc_hi;
    logic [31:0]      calc_lo;
    logic             calc_div0;

    md_calc u_calc (
        .op   (md_op),
        .a    (A),
        .b    (B),
        .hi   (calc_hi),
        .lo   (calc_lo),
        .div0 (calc_div0)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_hi_d   = pend_hi_q;
        pend_lo_d   = pend_lo_q;
        pend_skip_d = pend_skip_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        case (state_q)
            MD_IDLE: begin
                if (start && is_muldiv(md_op)) begin
                    pend_hi_d   = calc_hi;
                    pend_lo_d   = calc_lo;
                    pend_skip_d = calc_div0;
                    cnt_d       = is_div(md_op) ? DIV_LOAD : MUL_LOAD;
                    state_d     = MD_BUSY;
                end else if (start && (md_op == MD_MTHI)) begin
                    hi_d = A;
                end else if (start && (md_op == MD_MTLO)) begin
                    lo_d = A;
                end
            end
            MD_BUSY: begin
                // Divide by zero still burns the full window but leaves HI/LO alone.
                if (cnt_q == '0) begin
                    state_d = MD_IDLE;
                    if (!pend_skip_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= MD_IDLE;
            cnt_q       <= '0;
            pend_hi_q   <= 32'd0;
            pend_lo_q   <= 32'd0;
            pend_skip_q <= 1'b0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_hi_q   <= pend_hi_d;
            pend_lo_q   <= pend_lo_d;
            pend_skip_q <= pend_skip_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    assign busy     = (state_q == MD_BUSY);
    assign stall    = md_req & (busy | (start & is_muldiv(md_op)));
    assign md_rdata = rd_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: expected HI/LO pushed at start, popped and
// compared once busy drops; also covers MT writes, reset and stall behaviour.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        rd_hi;
    logic        md_req;
    logic        busy;
    logic        stall;
    logic [31:0] md_rdata;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] mhi;
    logic [31:0] mlo;
    logic [63:0] exp_q[$];

    mdu_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .A        (A),
        .B        (B),
        .rd_hi    (rd_hi),
        .md_req   (md_req),
        .busy     (busy),
        .stall    (stall),
        .md_rdata (md_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Reference model written with 64-bit language arithmetic.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub;
        logic [63:0]     res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        res = {hi, lo};
        case (op)
            MD_MULT:  res = sa * sb;
            MD_MULTU: res = ua * ub;
            MD_DIV:   if (b != 32'd0) begin
                sq = sa / sb;
                sr = sa % sb;
                res = {sr[31:0], sq[31:0]};
            end
            MD_DIVU:  if (b != 32'd0) res = {a % b, a / b};
            default:  res = {hi, lo};
        endcase
        return res;
    endfunction

    task automatic read_hilo(input string tag);
        rd_hi = 1'b1;
        #1 check({tag, " HI"}, {32'd0, md_rdata}, {32'd0, mhi});
        rd_hi = 1'b0;
        #1 check({tag, " LO"}, {32'd0, md_rdata}, {32'd0, mlo});
    endtask

    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int ncyc, input bit inject, input string tag);
        int n;
        logic [63:0] r;
        @(posedge clk); #1;
        start = 1'b1; md_op = op; A = a; B = b;
        exp_q.push_back(model(op, a, b, mhi, mlo));
        @(negedge clk);
        check({tag, " stall@start"}, {63'd0, stall}, {63'd0, md_req});
        @(posedge clk); #1;
        start = 1'b0; md_op = MD_NONE; A = $urandom; B = $urandom;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (stall !== md_req) check({tag, " stall@busy"}, {63'd0, stall}, {63'd0, md_req});
            if (inject && n == 2) begin
                start = 1'b1; md_op = MD_MTLO; A = 32'h0000AAAA;
            end
            if (inject && n == 3) begin
                start = 1'b0; md_op = MD_NONE;
            end
        end
        check({tag, " busy cycles"}, 64'(n), 64'(ncyc));
        check({tag, " stall@idle"}, {63'd0, stall}, 64'd0);
        if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            mhi = r[63:32];
            mlo = r[31:0];
        end
        read_hilo(tag);
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] a, input string tag);
        @(posedge clk); #1;
        start = 1'b1; md_op = op; A = a;
        @(negedge clk);
        check({tag, " busy"}, {63'd0, busy}, 64'd0);
        read_hilo({tag, " pre"});
        @(posedge clk); #1;
        start = 1'b0; md_op = MD_NONE;
        if (op == MD_MTHI) mhi = a;
        else mlo = a;
        @(negedge clk);
        check({tag, " busy after"}, {63'd0, busy}, 64'd0);
        read_hilo(tag);
    endtask

    initial begin
        int n;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        reset = 1'b1; start = 1'b0; md_op = MD_NONE; A = 32'd0; B = 32'd0;
        rd_hi = 1'b0; md_req = 1'b1; mhi = 32'd0; mlo = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset stall", {63'd0, stall}, 64'd0);
        read_hilo("reset");
        reset = 1'b0;

        run_md(MD_MULT,  32'hFFFFFFFE, 32'd3, 5, 1'b0, "mult");
        run_md(MD_MULTU, 32'hFFFFFFFF, 32'd2, 5, 1'b0, "multu");
        md_req = 1'b0;
        run_md(MD_DIV,   32'hFFFFFFF9, 32'd2, 10, 1'b0, "div");
        run_md(MD_DIVU,  32'd7,        32'd2, 10, 1'b0, "divu");
        run_md(MD_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 1'b0, "div ovf");

        mt(MD_MTHI, 32'h00001234, "mthi");
        mt(MD_MTLO, 32'h00005678, "mtlo");
        md_req = 1'b1;
        run_md(MD_DIV,  32'd5, 32'd0, 10, 1'b0, "div0");
        run_md(MD_DIVU, 32'd9, 32'd0, 10, 1'b0, "divu0");

        // start with MD_NONE must do nothing
        @(posedge clk); #1;
        start = 1'b1; md_op = MD_NONE; A = 32'hDEADBEEF;
        @(negedge clk);
        check("none stall", {63'd0, stall}, 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("none busy", {63'd0, busy}, 64'd0);
        read_hilo("none");

        run_md(MD_MULT, 32'd3, 32'd4, 5, 1'b1, "mid-busy mtlo");

        // Reset at the third busy cycle abandons the operation.
        @(posedge clk); #1;
        start = 1'b1; md_op = MD_MULTU; A = 32'h00010000; B = 32'h00010000;
        @(posedge clk); #1;
        start = 1'b0; md_op = MD_NONE;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (busy) n++;
        end
        check("pre-reset busy", 64'(n), 64'd3);
        reset = 1'b1;
        mhi = 32'd0; mlo = 32'd0;
        #1 check("reset mid busy", {63'd0, busy}, 64'd0);
        read_hilo("reset mid");
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy) n++;
        end
        check("post-reset busy", 64'(n), 64'd0);
        read_hilo("post-reset");

        for (int k = 0; k < 8; k++) begin
            rop = 3'(1 + $urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if (k == 0) ra = 32'h80000000;
            md_req = 1'($urandom_range(0, 1));
            run_md(rop, ra, rb, is_div(rop) ? 10 : 5, 1'b0, $sformatf("rand%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
